// File: rtl/store_unit_if.sv
// Store unit bus bundle: pipeline request side plus data-memory write port.
// The slave modport is the store unit; the master modport is its environment.
interface store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  store_control;
   logic [31:0] base_addr;
   logic [11:0] imm;
   logic [31:0] store_data;
   logic        mem_wvalid;
   logic        mem_wready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        misalign_err;
   logic [31:0] err_addr;
   logic        buf_empty;

   modport master (
      output req_valid, store_control, base_addr, imm, store_data, mem_wready,
      input  req_ready, mem_wvalid, mem_addr, mem_wdata, mem_wstrb,
             misalign_err, err_addr, buf_empty
   );

   modport slave (
      input  req_valid, store_control, base_addr, imm, store_data, mem_wready,
      output req_ready, mem_wvalid, mem_addr, mem_wdata, mem_wstrb,
             misalign_err, err_addr, buf_empty
   );
endinterface

// File: rtl/store_unit.sv
// Store unit: effective-address generation, alignment check, byte-lane
// formatting and an in-order store buffer feeding the data-memory write port.
module store_unit #(
   parameter int unsigned DEPTH = 4
) (
   input logic         clk,
   input logic         rst_n,
   store_unit_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

   // Store control encodings (processor_defines.sv)
   localparam logic [2:0] SB      = 3'b000;
   localparam logic [2:0] SH      = 3'b001;
   localparam logic [2:0] SW      = 3'b010;
   localparam logic [2:0] STR_NOP = 3'b111;

   logic [31:0]      ea;
   logic [1:0]       off;
   logic [31:0]      fmt_wdata;
   logic [3:0]       fmt_wstrb;
   logic             fmt_ok;
   logic             fmt_bad;
   logic             accept;
   logic             push;
   logic             pop;

   logic [31:0]      addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [3:0]       strb_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic [PTR_W:0]   count_d;
   logic             err_q;
   logic [31:0]      err_addr_q;

   assign ea  = bus.base_addr + {{20{bus.imm[11]}}, bus.imm};
   assign off = ea[1:0];

   // Lane formatting and alignment classification of the incoming store
   always_comb begin
      fmt_ok    = 1'b0;
      fmt_bad   = 1'b0;
      fmt_wdata = '0;
      fmt_wstrb = '0;
      case (bus.store_control)
         SB: begin
            fmt_ok    = 1'b1;
            fmt_wstrb = 4'b0001 << off;
            fmt_wdata = {4{bus.store_data[7:0]}};
         end
         SH: begin
            fmt_wdata = {2{bus.store_data[15:0]}};
            if (off == 2'd0) begin
               fmt_ok    = 1'b1;
               fmt_wstrb = 4'b0011;
            end else if (off == 2'd2) begin
               fmt_ok    = 1'b1;
               fmt_wstrb = 4'b1100;
            end else begin
               fmt_bad = 1'b1;
            end
         end
         SW: begin
            fmt_wdata = bus.store_data;
            if (off == 2'd0) begin
               fmt_ok    = 1'b1;
               fmt_wstrb = 4'b1111;
            end else begin
               fmt_bad = 1'b1;
            end
         end
         STR_NOP: ;   // accepted and dropped
         default: ;   // unknown codes behave as a NOP
      endcase
   end

   // Ready depends only on occupancy so it never loops back through req_valid
   assign bus.req_ready = (count_q != FULL);
   assign accept        = bus.req_valid && bus.req_ready;
   assign push          = accept && fmt_ok;
   assign pop           = bus.mem_wvalid && bus.mem_wready;

   // Occupancy next-state; push and pop together leave it unchanged
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Buffer storage; cleared on reset so the idle write port reads zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
            strb_q[i] <= '0;
         end
      end else if (push) begin
         addr_q[wr_ptr_q] <= {ea[31:2], 2'b00};
         data_q[wr_ptr_q] <= fmt_wdata;
         strb_q[wr_ptr_q] <= fmt_wstrb;
      end
   end

   // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // Misalignment pulse and sticky faulting address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         err_q <= accept && fmt_bad;
         if (accept && fmt_bad) err_addr_q <= ea;
      end
   end

   assign bus.mem_wvalid   = (count_q != '0);
   assign bus.buf_empty    = (count_q == '0);
   assign bus.mem_addr     = addr_q[rd_ptr_q];
   assign bus.mem_wdata    = data_q[rd_ptr_q];
   assign bus.mem_wstrb    = strb_q[rd_ptr_q];
   assign bus.misalign_err = err_q;
   assign bus.err_addr     = err_addr_q;
endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: single-store vector table, then back-pressure,
// toggling-ready wrap and mid-stream reset sequences.
module tb_store_unit;
   localparam logic [2:0] SB      = 3'b000;
   localparam logic [2:0] SH      = 3'b001;
   localparam logic [2:0] SW      = 3'b010;
   localparam logic [2:0] STR_NOP = 3'b111;

   logic clk;
   logic rst_n;
   store_unit_if bus ();

   store_unit #(.DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  ctrl;
      logic [31:0] base;
      logic [11:0] imm;
      logic [31:0] data;
      logic        exp_valid;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_wstrb;
      logic        exp_err;
      logic [31:0] exp_err_addr;
   } vec_t;

   vec_t        vec [12];
   int          total = 0;
   int          bad   = 0;
   logic [63:0] got [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Record a write that fires at the coming edge, then advance one cycle
   task automatic cycle();
      if (bus.mem_wvalid && bus.mem_wready) got.push_back({bus.mem_addr, bus.mem_wdata});
      @(negedge clk);
   endtask

   task automatic set_req(input logic [2:0] c, input logic [31:0] b, input logic [11:0] i,
                          input logic [31:0] d);
      bus.store_control = c;
      bus.base_addr     = b;
      bus.imm           = i;
      bus.store_data    = d;
      bus.req_valid     = 1'b1;
   endtask

   initial begin
      vec[0]  = '{SW,      32'h0000_1000, 12'h004, 32'hDEAD_BEEF,
                  1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
      vec[1]  = '{SB,      32'h0000_2000, 12'hFFF, 32'h0000_00A5,
                  1'b1, 32'h0000_1FFC, 32'hA5A5_A5A5, 4'h8, 1'b0, 32'h0};
      vec[2]  = '{SH,      32'h0000_2000, 12'h002, 32'h1234_BEEF,
                  1'b1, 32'h0000_2000, 32'hBEEF_BEEF, 4'hC, 1'b0, 32'h0};
      vec[3]  = '{SW,      32'h0000_3000, 12'h002, 32'h1111_2222,
                  1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 32'h0000_3002};
      vec[4]  = '{STR_NOP, 32'h0000_4000, 12'h001, 32'h3333_4444,
                  1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 32'h0000_3002};
      vec[5]  = '{SH,      32'h0000_5000, 12'h001, 32'h0000_7777,
                  1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 32'h0000_5001};
      vec[6]  = '{SB,      32'h0000_6000, 12'h7FF, 32'h0000_005A,
                  1'b1, 32'h0000_67FC, 32'h5A5A_5A5A, 4'h8, 1'b0, 32'h0000_5001};
      vec[7]  = '{SB,      32'h0000_0100, 12'h001, 32'hFFFF_FF3C,
                  1'b1, 32'h0000_0100, 32'h3C3C_3C3C, 4'h2, 1'b0, 32'h0000_5001};
      vec[8]  = '{SH,      32'h0000_0000, 12'h800, 32'h0000_CAFE,
                  1'b1, 32'hFFFF_F800, 32'hCAFE_CAFE, 4'h3, 1'b0, 32'h0000_5001};
      vec[9]  = '{SW,      32'hFFFF_FFFC, 12'h008, 32'h1122_3344,
                  1'b1, 32'h0000_0004, 32'h1122_3344, 4'hF, 1'b0, 32'h0000_5001};
      vec[10] = '{3'b101,  32'h0000_8000, 12'h000, 32'h5555_6666,
                  1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 32'h0000_5001};
      vec[11] = '{SW,      32'h0000_7000, 12'hFFD, 32'h7777_8888,
                  1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 32'h0000_6FFD};

      // Reset with a request pending
      rst_n = 1'b0;
      bus.mem_wready = 1'b1;
      set_req(SW, 32'h1000, 12'h004, 32'hDEAD_BEEF);
      #3;
      chk("rst req_ready",  32'(bus.req_ready), 32'd1);
      chk("rst wvalid",     32'(bus.mem_wvalid), 32'd0);
      chk("rst buf_empty",  32'(bus.buf_empty), 32'd1);
      chk("rst addr",       bus.mem_addr, 32'h0);
      chk("rst wdata",      bus.mem_wdata, 32'h0);
      chk("rst wstrb",      32'(bus.mem_wstrb), 32'h0);
      chk("rst misalign",   32'(bus.misalign_err), 32'd0);
      chk("rst err_addr",   bus.err_addr, 32'h0);
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // One store at a time with the memory always ready
      foreach (vec[k]) begin
         @(negedge clk);
         set_req(vec[k].ctrl, vec[k].base, vec[k].imm, vec[k].data);
         @(negedge clk);
         bus.req_valid = 1'b0;
         chk($sformatf("v%0d wvalid", k), 32'(bus.mem_wvalid), 32'(vec[k].exp_valid));
         if (vec[k].exp_valid) begin
            chk($sformatf("v%0d addr", k),  bus.mem_addr, vec[k].exp_addr);
            chk($sformatf("v%0d wdata", k), bus.mem_wdata, vec[k].exp_wdata);
            chk($sformatf("v%0d wstrb", k), 32'(bus.mem_wstrb), 32'(vec[k].exp_wstrb));
         end
         chk($sformatf("v%0d misalign", k), 32'(bus.misalign_err), 32'(vec[k].exp_err));
         chk($sformatf("v%0d err_addr", k), bus.err_addr, vec[k].exp_err_addr);
         @(negedge clk);
         chk($sformatf("v%0d empty after", k), 32'(bus.buf_empty), 32'd1);
         chk($sformatf("v%0d pulse end", k), 32'(bus.misalign_err), 32'd0);
      end

      // Back-pressure: fill the buffer, fifth request must wait for a pop
      got.delete();
      bus.mem_wready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_req(SW, 32'h8000 + 32'(4 * i), 12'h000, 32'hA000_0000 + 32'(i));
         chk($sformatf("bp ready %0d", i), 32'(bus.req_ready), (i == 4) ? 32'd0 : 32'd1);
         cycle();
      end
      for (int s = 0; s < 2; s++) begin
         chk("bp stall wvalid", 32'(bus.mem_wvalid), 32'd1);
         chk("bp stall addr",   bus.mem_addr, 32'h8000);
         chk("bp stall wdata",  bus.mem_wdata, 32'hA000_0000);
         chk("bp stall ready",  32'(bus.req_ready), 32'd0);
         cycle();
      end
      bus.mem_wready = 1'b1;
      cycle();
      chk("bp ready after pop", 32'(bus.req_ready), 32'd1);
      cycle();
      bus.req_valid = 1'b0;
      for (int t = 0; t < 20 && got.size() < 5; t++) cycle();
      chk("bp write count", 32'(got.size()), 32'd5);
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         chk($sformatf("bp order addr %0d", i), got[i][63:32], 32'h8000 + 32'(4 * i));
         chk($sformatf("bp order data %0d", i), got[i][31:0], 32'hA000_0000 + 32'(i));
      end

      // Continuous traffic with ready toggling; ten stores wrap the pointers
      begin
         int   idx;
         logic fire;
         idx = 0;
         got.delete();
         for (int c = 0; c < 100 && got.size() < 10; c++) begin
            bus.mem_wready = c[0];
            if (idx < 10) set_req(SW, 32'h9000, 12'(4 * idx), 32'hC0DE_0000 + 32'(idx));
            else bus.req_valid = 1'b0;
            fire = bus.req_valid && bus.req_ready;
            cycle();
            if (fire) idx++;
         end
         bus.req_valid = 1'b0;
         chk("wrap write count", 32'(got.size()), 32'd10);
         for (int i = 0; i < 10 && i < got.size(); i++) begin
            chk($sformatf("wrap addr %0d", i), got[i][63:32], 32'h9000 + 32'(4 * i));
            chk($sformatf("wrap data %0d", i), got[i][31:0], 32'hC0DE_0000 + 32'(i));
         end
      end

      // Reset mid-stream drops queued stores at once
      bus.mem_wready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_req(SW, 32'hB000 + 32'(4 * i), 12'h000, 32'hB0B0_0000 + 32'(i));
         cycle();
      end
      bus.req_valid = 1'b0;
      chk("mid wvalid before", 32'(bus.mem_wvalid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid rst wvalid",    32'(bus.mem_wvalid), 32'd0);
      chk("mid rst empty",     32'(bus.buf_empty), 32'd1);
      chk("mid rst ready",     32'(bus.req_ready), 32'd1);
      chk("mid rst addr",      bus.mem_addr, 32'h0);
      chk("mid rst err_addr",  bus.err_addr, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.mem_wready = 1'b1;
      @(negedge clk);
      set_req(SW, 32'hA000, 12'h000, 32'h0BAD_F00D);
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("post rst wvalid", 32'(bus.mem_wvalid), 32'd1);
      chk("post rst addr",   bus.mem_addr, 32'hA000);
      chk("post rst wdata",  bus.mem_wdata, 32'h0BAD_F00D);
      @(negedge clk);
      chk("post rst empty",  32'(bus.buf_empty), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Execute/memory-stage store unit; consumes the decoded store fields (rs1 value, rs2 value, 12-bit imm, 3-bit store_control) and produces byte-lane write transactions on the data-memory write port.
- Computes the effective address, checks alignment and lane-aligns the data. Generates byte strobes.
- Buffers accepted stores in a small FIFO, so the pipeline does not stall on single memory back-pressure cycles.

Parameters:
- DEPTH, 4, store-buffer entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  store request valid
- req_ready  output  1  unit can accept a request this cycle
- store_control  input  3  `SB / `SH / `SW / `STR_NOP per processor_defines.sv
- base_addr  input  32  rs1 register value
- imm  input  12  signed store offset
- store_data  input  32  rs2 register value
- mem_wvalid  output  1  write transaction valid
- mem_wready  input  1  memory accepts the write
- mem_addr  output  32  word-aligned write address, [1:0]=0
- mem_wdata  output  32  lane-aligned write data
- mem_wstrb  output  4  byte enables; bit i covers wdata[8i+7:8i]
- misalign_err  output  1  one-cycle pulse on a misaligned store
- err_addr  output  32  effective address of the last misaligned store
- buf_empty  output  1  store buffer empty

Behaviour:
- Reset (async assert, sync deassert by the system):
  - FIFO is empty; count=0.
  - req_ready=1, mem_wvalid=0, mem_addr/mem_wdata/mem_wstrb=0, misalign_err=0, err_addr=0, buf_empty=1.
- Handshakes:
  - Accept when req_valid && req_ready.
  - req_ready = (count != DEPTH), combinational from state only, never from req_valid.
  - There is no same-cycle bypass when full.
- Effective address: ea = base_addr + sign_extend(imm), modulo 2^32 (wrap-around, no error). off = ea[1:0].
- Formatting by store_control:
  - SB: wstrb = 4'b0001 << off; wdata = {4{store_data[7:0]}}.
  - SH: off==0 gives 4'b0011, off==2 gives 4'b1100; wdata = {2{store_data[15:0]}}. off 1 or 3 is misaligned.
  - SW: off==0 gives 4'b1111; wdata = store_data. Any other off is misaligned.
  - STR_NOP, or any unlisted code: request is accepted and dropped. No enqueue, no error.
- Misaligned request:
  - Accepted and not enqueued.
  - Next cycle: misalign_err=1 for exactly one cycle, and err_addr = ea. err_addr holds until the next error.
- Enqueue: an aligned request pushes {ea[31:2],2'b00, wdata, wstrb}. Earliest mem_wvalid is the cycle after acceptance (registered, 1-cycle latency).
- Memory side:
  - mem_wvalid = !buf_empty. mem_addr/wdata/wstrb come from the head entry.
  - Pop on mem_wvalid && mem_wready.
  - Outputs stay stable while mem_wvalid && !mem_wready.
  - When empty, the outputs drive the stale head entry with wvalid=0; zero after reset.
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, req_ready=0, so a pop that cycle frees a slot visible the next cycle.
- Pointers wrap modulo DEPTH. Stores issue strictly in order.
- Reset asserted mid-transaction: all entries are discarded immediately and mem_wvalid drops asynchronously.

Test Plan:
- Reset with req_valid=1 → req_ready=1, mem_wvalid=0, buf_empty=1, all outputs 0.
- SW base=0x1000, imm=0x004, data=0xDEADBEEF, mem_wready=1 → next cycle: addr=0x1004, wdata=0xDEADBEEF, wstrb=4'hF; popped the same cycle; buf_empty returns to 1.
- SB base=0x2000, imm=0xFFF(-1), data=0x000000A5 → addr=0x1FFC, wstrb=4'b1000, wdata=0xA5A5A5A5. SH to ea=0x2002 → wstrb=4'b1100, wdata=halfword replicated.
- SW to ea=0x3002 → misalign_err pulses one cycle, err_addr=0x3002, no mem_wvalid. STR_NOP → no write, no error.
- mem_wready=0 with 5 back-to-back SW (DEPTH=4) → 4 accepted, req_ready=0 on the 5th, outputs stable. Then mem_wready=1 → 4 writes in order, the 5th is accepted after the first pop.
- Continuous push and pop with mem_wready toggling every cycle across 10 stores → order preserved through pointer wrap. Assert rst_n low mid-stream → mem_wvalid=0 immediately, buffer empty.
